// File: rtl/uart_rx_fifo.sv
// UART receiver with first-word-fall-through receive FIFO and sticky
// framing/parity/overrun flags. LSB-first frames, configurable width/parity.
module uart_rx_fifo #(
  parameter int BAUD_CNT  = 1,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int FIFO_AW   = 2
) (
  input  logic                 mclk,
  input  logic                 puc_rst,
  input  logic                 rx,
  input  logic                 rx_en,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  output logic [FIFO_AW:0]     fifo_level,
  output logic                 overrun,
  output logic                 frame_err,
  output logic                 parity_err,
  input  logic                 err_clr
);

  localparam int DEPTH  = 2 ** FIFO_AW;
  localparam int CW     = $clog2(BAUD_CNT + 1) + 1;
  localparam int HALF_I = ((BAUD_CNT + 1) / 2 > 0) ? (BAUD_CNT + 1) / 2 - 1 : 0;
  localparam logic [CW-1:0]    CNT_BIT  = CW'(BAUD_CNT);
  localparam logic [CW-1:0]    CNT_HALF = CW'(HALF_I);
  localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t               state, state_nxt;
  logic                 rx_m, rx_s, rx_prev;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [3:0]           idx, idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 par_bit, par_nxt;
  logic                 par_ok;
  logic                 push, pop, full;
  logic                 fe_set, pe_set, ov_set;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;

  assign pop      = rd_en && rd_valid;
  assign full     = (fifo_level == LVL_FULL);
  assign rd_valid = (fifo_level != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  // Two-flop synchroniser plus previous-value flop for start-edge detection
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  // Receiver state and bit-timing registers
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      shreg   <= shreg_nxt;
      par_bit <= par_nxt;
    end
  end

  // Next-state, bit sampling and end-of-frame decision
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    par_nxt   = par_bit;
    push      = 1'b0;
    fe_set    = 1'b0;
    pe_set    = 1'b0;
    ov_set    = 1'b0;
    par_ok    = (PARITY == 0) || (((^shreg) ^ par_bit) == (PARITY == 2));

    if (state != ST_IDLE && !rx_en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_en && rx_prev && !rx_s) begin
            state_nxt = ST_START;
            cnt_nxt   = CNT_HALF;
          end
        end
        ST_START: begin
          if (cnt == '0) begin
            if (rx_s) begin
              state_nxt = ST_IDLE;
            end else begin
              state_nxt = ST_DATA;
              cnt_nxt   = CNT_BIT;
              idx_nxt   = '0;
            end
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        ST_DATA: begin
          if (cnt == '0) begin
            shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
            cnt_nxt   = CNT_BIT;
            idx_nxt   = idx + 4'd1;
            if (idx == LAST_BIT)
              state_nxt = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        ST_PARITY: begin
          if (cnt == '0) begin
            par_nxt   = rx_s;
            cnt_nxt   = CNT_BIT;
            state_nxt = ST_STOP;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        ST_STOP: begin
          if (cnt == '0) begin
            // Leave mid stop bit so a back-to-back start edge is not missed
            state_nxt = ST_IDLE;
            if (!rx_s)              fe_set = 1'b1;
            else if (!par_ok)       pe_set = 1'b1;
            else if (full && !pop)  ov_set = 1'b1;
            else                    push   = 1'b1;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // FIFO storage write port
  always_ff @(posedge mclk) begin
    if (push)
      mem[wr_ptr] <= shreg;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Sticky error flags; a set event overrides a same-cycle clear
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      overrun    <= ov_set | (overrun    & ~err_clr);
      frame_err  <= fe_set | (frame_err  & ~err_clr);
      parity_err <= pe_set | (parity_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: three parameterisations driven by directed and
// random frames, checked against a frame-level queue model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 4;

  logic       mclk = 1'b0;
  logic       puc_rst;
  logic       rx_en;
  logic [2:0] rx_v, rd_en_v, clr_v;

  logic [7:0] rd_data0, rd_data1;
  logic [8:0] rd_data2;
  logic [2:0] lvl0, lvl1, lvl2;
  logic       val0, val1, val2;
  logic       ov0, ov1, ov2, fe0, fe1, fe2, pe0, pe1, pe2;

  int unsigned sel;
  logic [8:0]  o_data;
  logic [2:0]  o_level;
  logic        o_valid, o_ov, o_fe, o_pe;

  int n_checks = 0;
  int n_pass   = 0;

  int mq[$];
  bit m_fe, m_pe, m_ov;

  always #5 mclk = ~mclk;

  uart_rx_fifo u0 (
    .mclk(mclk), .puc_rst(puc_rst), .rx(rx_v[0]), .rx_en(rx_en), .rd_en(rd_en_v[0]),
    .rd_data(rd_data0), .rd_valid(val0), .fifo_level(lvl0), .overrun(ov0),
    .frame_err(fe0), .parity_err(pe0), .err_clr(clr_v[0])
  );

  uart_rx_fifo #(.BAUD_CNT(7), .PARITY(1)) u1 (
    .mclk(mclk), .puc_rst(puc_rst), .rx(rx_v[1]), .rx_en(rx_en), .rd_en(rd_en_v[1]),
    .rd_data(rd_data1), .rd_valid(val1), .fifo_level(lvl1), .overrun(ov1),
    .frame_err(fe1), .parity_err(pe1), .err_clr(clr_v[1])
  );

  uart_rx_fifo #(.DATA_BITS(9)) u2 (
    .mclk(mclk), .puc_rst(puc_rst), .rx(rx_v[2]), .rx_en(rx_en), .rd_en(rd_en_v[2]),
    .rd_data(rd_data2), .rd_valid(val2), .fifo_level(lvl2), .overrun(ov2),
    .frame_err(fe2), .parity_err(pe2), .err_clr(clr_v[2])
  );

  // Route the selected instance to a common set of observation signals
  always_comb begin
    case (sel)
      0: begin
        o_data = {1'b0, rd_data0}; o_valid = val0; o_level = lvl0;
        o_ov = ov0; o_fe = fe0; o_pe = pe0;
      end
      1: begin
        o_data = {1'b0, rd_data1}; o_valid = val1; o_level = lvl1;
        o_ov = ov1; o_fe = fe1; o_pe = pe1;
      end
      default: begin
        o_data = rd_data2; o_valid = val2; o_level = lvl2;
        o_ov = ov2; o_fe = fe2; o_pe = pe2;
      end
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int p_of(input int unsigned k);
    return (k == 1) ? 8 : 2;
  endfunction

  function automatic int nb_of(input int unsigned k);
    return (k == 2) ? 9 : 8;
  endfunction

  function automatic int hp_of(input int unsigned k);
    return (k == 1) ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".level"}, 32'(o_level), mq.size());
    check_eq({tag, ".valid"}, 32'(o_valid), (mq.size() > 0) ? 1 : 0);
    check_eq({tag, ".data"},  32'(o_data),  (mq.size() > 0) ? mq[0] : 0);
    check_eq({tag, ".frame_err"},  32'(o_fe), 32'(m_fe));
    check_eq({tag, ".parity_err"}, 32'(o_pe), 32'(m_pe));
    check_eq({tag, ".overrun"},    32'(o_ov), 32'(m_ov));
  endtask

  task automatic do_reset();
    puc_rst = 1'b1;
    repeat (3) tick();
    puc_rst = 1'b0;
    mq.delete();
    m_fe = 0; m_pe = 0; m_ov = 0;
  endtask

  task automatic do_pop();
    rd_en_v[sel] = 1'b1;
    tick();
    rd_en_v[sel] = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic do_clear();
    clr_v[sel] = 1'b1;
    tick();
    clr_v[sel] = 1'b0;
    m_fe = 0; m_pe = 0; m_ov = 0;
  endtask

  // Drive one frame on the selected rx pin; optionally pulse rd_en in the
  // cycle whose closing edge samples the stop bit (sync 2 + edge 1 + P/2-1)
  task automatic send_frame(input logic [8:0] data, input logic par_val,
                            input logic stop_val, input int gap, input bit pop_at_stop);
    int   p, nb, hp, nbits, total, pop_cyc;
    logic bits[$];
    p  = p_of(sel);
    nb = nb_of(sel);
    hp = hp_of(sel);
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits.push_back(data[i]);
    if (hp != 0) bits.push_back(par_val);
    bits.push_back(stop_val);
    nbits   = bits.size();
    pop_cyc = pop_at_stop ? 3 + (p / 2 - 1) + (nbits - 1) * p : -1;
    total   = nbits * p + gap;
    if (pop_cyc + 1 > total) total = pop_cyc + 1;
    for (int c = 0; c < total; c++) begin
      rx_v[sel]    = (c < nbits * p) ? bits[c / p] : 1'b1;
      rd_en_v[sel] = (c == pop_cyc);
      tick();
    end
    rx_v[sel]    = 1'b1;
    rd_en_v[sel] = 1'b0;
  endtask

  // Frame-level model: errors in priority order, then capacity, then store
  task automatic send(input logic [8:0] data, input bit par_good, input bit stop_ok,
                      input int gap, input bit pop_same);
    logic par_val;
    bit   can_pop, was_full;
    par_val  = (hp_of(sel) != 0) ? ((^data) ^ !par_good) : 1'b1;
    can_pop  = pop_same && (mq.size() > 0);
    was_full = (mq.size() == DEPTH);
    send_frame(data, par_val, stop_ok, gap, pop_same);
    if (can_pop) void'(mq.pop_front());
    if (!stop_ok)                  m_fe = 1;
    else if (!par_good)            m_pe = 1;
    else if (was_full && !can_pop) m_ov = 1;
    else                           mq.push_back(int'(data));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    puc_rst = 1'b1;
    rx_en   = 1'b1;
    rx_v    = '1;
    rd_en_v = '0;
    clr_v   = '0;
    sel     = 0;

    // Default 8N1, P=2
    do_reset();
    check_state("t1.reset");
    send(9'h41, 1, 1, 6, 0);
    check_eq("t1.data", 32'(o_data), 32'h41);
    check_state("t1.rx");
    do_pop();
    check_state("t1.pop");

    for (int i = 1; i <= 5; i++) send(9'(i), 1, 1, (i == 5) ? 6 : 0, 0);
    check_eq("t2.level", 32'(o_level), 4);
    check_eq("t2.overrun", 32'(o_ov), 1);
    check_state("t2.full");
    for (int i = 1; i <= 4; i++) begin
      check_eq("t2.head", 32'(o_data), i);
      do_pop();
    end
    check_state("t2.drained");
    do_clear();
    check_state("t2.clr");

    for (int i = 0; i < 4; i++) send(9'h11 + 9'(i), 1, 1, 6, 0);
    send(9'h06, 1, 1, 6, 1);
    check_eq("t3.overrun", 32'(o_ov), 0);
    check_eq("t3.level", 32'(o_level), 4);
    check_state("t3.full");
    for (int i = 0; i < 3; i++) do_pop();
    check_eq("t3.last", 32'(o_data), 32'h06);
    do_pop();
    check_state("t3.empty");

    send(9'h55, 1, 0, 6, 0);
    check_eq("t4.frame_err", 32'(o_fe), 1);
    check_state("t4.bad");
    send(9'hAA, 1, 1, 6, 0);
    check_state("t4.good");
    do_clear();
    check_state("t4.clr");
    do_pop();

    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 1)) do_pop();
      if ($urandom_range(0, 5) == 0) do_clear();
      send(9'($urandom_range(0, 255)), 1, $urandom_range(0, 7) != 0, 6,
           $urandom_range(0, 4) == 0);
      check_state("rnd0");
    end

    // 8E1, P=8
    sel = 1;
    do_reset();
    check_state("t5.reset");
    send(9'h03, 0, 1, 4, 0);
    check_eq("t5.parity_err", 32'(o_pe), 1);
    check_state("t5.badpar");
    send(9'h03, 1, 1, 4, 0);
    check_state("t5.goodpar");
    rx_v[1] = 1'b0;
    tick();
    rx_v[1] = 1'b1;
    repeat (30) tick();
    check_state("t5.glitch");
    send(9'h5A, 1, 1, 4, 0);
    check_state("t5.after_glitch");
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 1) == 0) do_pop();
      send(9'($urandom_range(0, 255)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 7) != 0, 4, 0);
      check_state("rnd1");
    end

    // 9N1, P=2
    sel = 2;
    do_reset();
    send(9'h1A5, 1, 1, 6, 0);
    check_eq("t6.data9", 32'(o_data), 32'h1A5);
    check_state("t6.first");
    rx_v[2] = 1'b0;
    repeat (8) tick();
    puc_rst = 1'b1;
    rx_v[2] = 1'b1;
    tick();
    puc_rst = 1'b0;
    mq.delete();
    m_fe = 0; m_pe = 0; m_ov = 0;
    check_state("t6.reset");
    repeat (10) tick();
    send(9'h0F0, 1, 1, 6, 0);
    check_state("t6.after");
    do_pop();
    check_state("t6.pop");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
